// File: rtl/bomb_pkg.sv
// Shared types and colours for the bomb stage panel: stage states, the RGB332 pixel
// struct and the fixed palette.
package bomb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    DEFUSED  = 2'd2,
    EXPLODED = 2'd3
  } stage_state_t;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;

  localparam rgb332_t C_BLACK = '{r: 3'd0, g: 3'd0, b: 2'd0};
  localparam rgb332_t C_BG    = '{r: 3'd2, g: 3'd2, b: 2'd1};
  localparam rgb332_t C_PANEL = '{r: 3'd5, g: 3'd5, b: 2'd2};
  localparam rgb332_t C_BAR   = '{r: 3'd5, g: 3'd7, b: 2'd1};
  localparam rgb332_t C_OK    = '{r: 3'd0, g: 3'd7, b: 2'd0};
  localparam rgb332_t C_ALERT = '{r: 3'd7, g: 3'd0, b: 2'd0};

endpackage

// File: rtl/bomb_fuse_timer.sv
// Stage FSM with frame-driven countdown and a blink phase generator.
// All counters advance on frame_start only; state_o is the FSM state itself.
module bomb_fuse_timer
  import bomb_pkg::*;
#(
  parameter int FUSE_TICKS      = 15,
  parameter int FRAMES_PER_TICK = 60,
  parameter int BLINK_FRAMES    = 15,
  parameter int TW              = $clog2(FUSE_TICKS + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frame_start,
  input  logic          arm,
  input  logic          defuse,
  output stage_state_t  state_o,
  output logic [TW-1:0] ticks_left_o,
  output logic          blink_ph_o
);

  localparam int FW  = (FRAMES_PER_TICK > 1) ? $clog2(FRAMES_PER_TICK) : 1;
  localparam int BLW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  stage_state_t   state_q, state_d;
  logic [TW-1:0]  ticks_q, ticks_d;
  logic [FW-1:0]  frame_cnt_q, frame_cnt_d;
  logic [BLW-1:0] blink_cnt_q, blink_cnt_d;
  logic           blink_ph_q, blink_ph_d;

  always_comb begin
    state_d     = state_q;
    ticks_d     = ticks_q;
    frame_cnt_d = frame_cnt_q;
    blink_cnt_d = blink_cnt_q;
    blink_ph_d  = blink_ph_q;

    if (frame_start) begin
      if (blink_cnt_q == BLW'(BLINK_FRAMES - 1)) begin
        blink_cnt_d = '0;
        blink_ph_d  = ~blink_ph_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        // Arming restarts both the countdown and the blink phase from a known point.
        if (arm) begin
          state_d     = ARMED;
          ticks_d     = TW'(FUSE_TICKS);
          frame_cnt_d = '0;
          blink_cnt_d = '0;
          blink_ph_d  = 1'b0;
        end
      end
      ARMED: begin
        // Defuse freezes the countdown, so it beats a coincident final tick.
        if (defuse) begin
          state_d = DEFUSED;
        end else if (frame_start) begin
          if (frame_cnt_q == FW'(FRAMES_PER_TICK - 1)) begin
            frame_cnt_d = '0;
            ticks_d     = ticks_q - 1'b1;
            if (ticks_q == TW'(1)) state_d = EXPLODED;
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ticks_q     <= TW'(FUSE_TICKS);
      frame_cnt_q <= '0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ticks_q     <= ticks_d;
      frame_cnt_q <= frame_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
    end
  end

  assign state_o      = state_q;
  assign ticks_left_o = ticks_q;
  assign blink_ph_o   = blink_ph_q;

endmodule

// File: rtl/bomb_stage_panel.sv
// Stage panel renderer: per-frame snapshot of the fuse timer plus a one-cycle pixel pipe.
// pix_valid qualifies x/y in the same cycle; there is no back-pressure, so every valid
// pixel yields a colour on pix_valid_out one clock later.
module bomb_stage_panel
  import bomb_pkg::*;
#(
  parameter int XW              = 7,
  parameter int YW              = 7,
  parameter int X0              = 4,
  parameter int Y0              = 4,
  parameter int PW              = 72,
  parameter int PH              = 52,
  parameter int BW              = 4,
  parameter int HDR_H           = 10,
  parameter int FUSE_TICKS      = 15,
  parameter int TICK_PX         = 4,
  parameter int FRAMES_PER_TICK = 60,
  parameter int WARN_TICKS      = 3,
  parameter int BLINK_FRAMES    = 15
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [XW-1:0]                     x,
  input  logic [YW-1:0]                     y,
  input  logic                              pix_valid,
  input  logic                              frame_start,
  input  logic                              arm,
  input  logic                              defuse,
  output logic [2:0]                        red,
  output logic [2:0]                        green,
  output logic [1:0]                        blue,
  output logic                              pix_valid_out,
  output stage_state_t                      state,
  output logic [$clog2(FUSE_TICKS+1)-1:0]   ticks_left
);

  localparam int TW = $clog2(FUSE_TICKS + 1);
  localparam int CW = ((XW > YW) ? XW : YW) + 1;

  localparam logic [CW-1:0] OX0 = CW'(X0);
  localparam logic [CW-1:0] OX1 = CW'(X0 + PW - 1);
  localparam logic [CW-1:0] OY0 = CW'(Y0);
  localparam logic [CW-1:0] OY1 = CW'(Y0 + PH - 1);
  localparam logic [CW-1:0] IX0 = CW'(X0 + BW);
  localparam logic [CW-1:0] IX1 = CW'(X0 + PW - 1 - BW);
  localparam logic [CW-1:0] IY0 = CW'(Y0 + BW);
  localparam logic [CW-1:0] IY1 = CW'(Y0 + PH - 1 - BW);
  localparam logic [CW-1:0] HX0 = CW'(X0 + BW + 1);
  localparam logic [CW-1:0] HX1 = CW'(X0 + PW - 2 - BW);
  localparam logic [CW-1:0] HY0 = CW'(Y0 + BW + 1);
  localparam logic [CW-1:0] HY1 = CW'(Y0 + BW + HDR_H);

  if (FUSE_TICKS * TICK_PX > PW - 2 * BW - 2) begin : g_fuse_fit_chk
    $error("fuse bar (FUSE_TICKS*TICK_PX) does not fit inside the header");
  end

  stage_state_t  live_state;
  logic [TW-1:0] live_ticks;
  logic          live_blink;

  bomb_fuse_timer #(
    .FUSE_TICKS      (FUSE_TICKS),
    .FRAMES_PER_TICK (FRAMES_PER_TICK),
    .BLINK_FRAMES    (BLINK_FRAMES),
    .TW              (TW)
  ) u_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_start  (frame_start),
    .arm          (arm),
    .defuse       (defuse),
    .state_o      (live_state),
    .ticks_left_o (live_ticks),
    .blink_ph_o   (live_blink)
  );

  // Snapshot taken at frame_start holds the pre-edge timer view for the whole frame.
  stage_state_t  sh_state_q;
  logic [TW-1:0] sh_ticks_q;
  logic          sh_blink_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_state_q <= IDLE;
      sh_ticks_q <= TW'(FUSE_TICKS);
      sh_blink_q <= 1'b0;
    end else if (frame_start) begin
      sh_state_q <= live_state;
      sh_ticks_q <= live_ticks;
      sh_blink_q <= live_blink;
    end
  end

  logic [CW-1:0] xe, ye, bar_end;
  logic          in_outer, in_inner, in_hdr, in_bar, border_alert;
  rgb332_t       pix_c, rgb_d, rgb_q;
  logic          pv_q;

  assign xe      = CW'(x);
  assign ye      = CW'(y);
  assign bar_end = HX0 + CW'(sh_ticks_q) * CW'(TICK_PX);

  assign in_outer = (xe >= OX0) && (xe <= OX1) && (ye >= OY0) && (ye <= OY1);
  assign in_inner = (xe >= IX0) && (xe <= IX1) && (ye >= IY0) && (ye <= IY1);
  assign in_hdr   = (xe >= HX0) && (xe <= HX1) && (ye >= HY0) && (ye <= HY1);
  assign in_bar   = xe < bar_end;

  assign border_alert = (sh_state_q == ARMED) && (sh_ticks_q <= TW'(WARN_TICKS)) && sh_blink_q;

  always_comb begin
    pix_c = C_BG;
    if (!in_outer) begin
      pix_c = C_BG;
    end else if (!in_inner) begin
      pix_c = border_alert ? C_ALERT : C_BLACK;
    end else if (in_hdr) begin
      case (sh_state_q)
        DEFUSED:  pix_c = C_OK;
        EXPLODED: pix_c = C_BG;
        default:  pix_c = in_bar ? C_BAR : C_BG;
      endcase
    end else begin
      pix_c = (sh_state_q == EXPLODED) ? C_ALERT : C_PANEL;
    end
  end

  assign rgb_d = pix_valid ? pix_c : C_BLACK;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q <= C_BLACK;
      pv_q  <= 1'b0;
    end else begin
      rgb_q <= rgb_d;
      pv_q  <= pix_valid;
    end
  end

  assign red           = rgb_q.r;
  assign green         = rgb_q.g;
  assign blue          = rgb_q.b;
  assign pix_valid_out = pv_q;
  assign state         = live_state;
  assign ticks_left    = live_ticks;

endmodule

// File: tb/tb_bomb_stage_panel.sv
// Bench for bomb_stage_panel: directed scenarios plus randomized frames, all scored
// against a frame-count based model of the panel.
module tb_bomb_stage_panel;

  localparam int X0 = 4, Y0 = 4, PW = 72, PH = 52, BW = 4, HDR_H = 10;
  localparam int FUSE = 15, TICK_PX = 4, FPT = 60, WARN = 3, BLINK = 15;

  localparam logic [7:0] K_BLACK = 8'h00;
  localparam logic [7:0] K_BG    = 8'h49;
  localparam logic [7:0] K_PANEL = 8'hB6;
  localparam logic [7:0] K_BAR   = 8'hBD;
  localparam logic [7:0] K_OK    = 8'h1C;
  localparam logic [7:0] K_ALERT = 8'hE0;

  // clock / reset
  logic clk, rst_n;
  logic [6:0] x, y;
  logic pix_valid, frame_start, arm, defuse;
  logic [2:0] red, green;
  logic [1:0] blue;
  logic pix_valid_out;
  logic [1:0] state;
  logic [3:0] ticks_left;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bomb_stage_panel dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .x             (x),
    .y             (y),
    .pix_valid     (pix_valid),
    .frame_start   (frame_start),
    .arm           (arm),
    .defuse        (defuse),
    .red           (red),
    .green         (green),
    .blue          (blue),
    .pix_valid_out (pix_valid_out),
    .state         (state),
    .ticks_left    (ticks_left)
  );

  // scoreboard
  int n_vec = 0;
  int n_err = 0;
  logic [8:0] exp_q[$];

  // model: frames counted since the last arm (or reset) drive ticks and blink phase
  int m_state, m_ticks, m_n;
  int sh_state, sh_ticks, sh_blink;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [31:0] rgb_now();
    return 32'({red, green, blue});
  endfunction

  task automatic model_reset();
    m_state = 0; m_ticks = FUSE; m_n = 0;
    sh_state = 0; sh_ticks = FUSE; sh_blink = 0;
  endtask

  function automatic logic [7:0] model_pix(input int px, input int py);
    int ix0, ix1, iy0, iy1;
    ix0 = X0 + BW; ix1 = X0 + PW - 1 - BW;
    iy0 = Y0 + BW; iy1 = Y0 + PH - 1 - BW;
    if (px < X0 || px > X0 + PW - 1 || py < Y0 || py > Y0 + PH - 1) return K_BG;
    if (px < ix0 || px > ix1 || py < iy0 || py > iy1)
      return (sh_state == 1 && sh_ticks <= WARN && sh_blink == 1) ? K_ALERT : K_BLACK;
    if (px >= ix0 + 1 && px <= ix1 - 1 && py >= iy0 + 1 && py <= iy0 + HDR_H) begin
      if (sh_state == 2) return K_OK;
      if (sh_state == 3) return K_BG;
      return (px < ix0 + 1 + sh_ticks * TICK_PX) ? K_BAR : K_BG;
    end
    return (sh_state == 3) ? K_ALERT : K_PANEL;
  endfunction

  task automatic model_update(input bit a, input bit d, input bit f);
    if (f) begin
      sh_state = m_state; sh_ticks = m_ticks; sh_blink = (m_n / BLINK) % 2;
    end
    if (m_state == 0 && a) begin
      m_state = 1; m_ticks = FUSE; m_n = 0;
    end else begin
      if (f) m_n++;
      if (m_state == 1) begin
        if (d) m_state = 2;
        else if (f) begin
          m_ticks = FUSE - m_n / FPT;
          if (m_ticks == 0) m_state = 3;
        end
      end
    end
  endtask

  // driver: one clock of stimulus, then score the registered outputs
  task automatic step(input bit a, input bit d, input bit f, input bit v, input int px, input int py);
    logic [8:0] e;
    arm = a; defuse = d; frame_start = f; pix_valid = v;
    x = px[6:0]; y = py[6:0];
    exp_q.push_back({v, v ? model_pix(px, py) : K_BLACK});
    @(posedge clk);
    model_update(a, d, f);
    #1;
    e = exp_q.pop_front();
    check("rgb", rgb_now(), 32'(e[7:0]));
    check("pvo", 32'(pix_valid_out), 32'(e[8]));
    check("state", 32'(state), 32'(m_state));
    check("ticks", 32'(ticks_left), 32'(m_ticks));
    arm = 1'b0; defuse = 1'b0; frame_start = 1'b0; pix_valid = 1'b0;
  endtask

  task automatic frame(input int npix, input bit ctl);
    int px, py;
    bit a, d, v;
    step(ctl && ($urandom_range(0, 29) == 0), 1'b0, 1'b1, $urandom_range(0, 1) == 1,
         $urandom_range(0, 79), $urandom_range(0, 59));
    for (int i = 0; i < npix; i++) begin
      px = $urandom_range(0, 79);
      py = $urandom_range(0, 59);
      a  = ctl && ($urandom_range(0, 39) == 0);
      d  = ctl && ($urandom_range(0, 149) == 0);
      v  = ($urandom_range(0, 3) != 0);
      step(a, d, 1'b0, v, px, py);
    end
  endtask

  task automatic apply_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check({tag, "_rgb"}, rgb_now(), 32'(K_BLACK));
    check({tag, "_pvo"}, 32'(pix_valid_out), 32'd0);
    check({tag, "_state"}, 32'(state), 32'd0);
    check({tag, "_ticks"}, 32'(ticks_left), 32'(FUSE));
    model_reset();
    exp_q.delete();
    arm = 1'b0; defuse = 1'b0; frame_start = 1'b0; pix_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; arm = 1'b0; defuse = 1'b0; frame_start = 1'b0; pix_valid = 1'b0;
    x = '0; y = '0;
    model_reset();
    @(posedge clk); #1;
    apply_reset("rst0");

    // default frame probes
    step(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 4, 4);   check("p4_4", rgb_now(), 32'(K_BLACK));
    step(1'b0, 1'b0, 1'b0, 1'b1, 9, 9);   check("p9_9", rgb_now(), 32'(K_BAR));
    step(1'b0, 1'b0, 1'b0, 1'b1, 68, 18); check("p68_18", rgb_now(), 32'(K_BAR));
    step(1'b0, 1'b0, 1'b0, 1'b1, 70, 18); check("p70_18", rgb_now(), 32'(K_BG));
    step(1'b0, 1'b0, 1'b0, 1'b1, 30, 30); check("p30_30", rgb_now(), 32'(K_PANEL));
    step(1'b0, 1'b0, 1'b0, 1'b1, 0, 0);   check("p0_0", rgb_now(), 32'(K_BG));
    step(1'b0, 1'b0, 1'b0, 1'b0, 30, 30); check("pv_lag", 32'(pix_valid_out), 32'd0);

    // first tick and shrunken bar
    step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < FPT; i++) frame(0, 1'b0);
    check("ticks14", 32'(ticks_left), 32'd14);
    step(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 64, 10); check("p64_10", rgb_now(), 32'(K_BAR));
    step(1'b0, 1'b0, 1'b0, 1'b1, 65, 10); check("p65_10", rgb_now(), 32'(K_BG));

    // warning blink: 61 frames consumed, run to 720 so ticks_left=3
    for (int i = 0; i < 720 - 61; i++) frame(0, 1'b0);
    check("ticks3", 32'(ticks_left), 32'd3);
    for (int j = 0; j < 45; j++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 5, 30);
      check("blink", rgb_now(), ((j / BLINK) % 2 == 1) ? 32'(K_ALERT) : 32'(K_BLACK));
    end

    // explosion at 900 frames (765 so far)
    for (int i = 0; i < 900 - 765; i++) frame(1, 1'b0);
    check("exploded", 32'(state), 32'd3);
    step(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 30, 30); check("p30_30_ex", rgb_now(), 32'(K_ALERT));
    step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);   check("arm_ignored", 32'(state), 32'd3);

    // arm + defuse together in IDLE, then defuse on the final tick
    apply_reset("rst1");
    step(1'b1, 1'b1, 1'b0, 1'b0, 0, 0);   check("arm_wins", 32'(state), 32'd1);
    for (int i = 0; i < 899; i++) frame(0, 1'b0);
    check("ticks1", 32'(ticks_left), 32'd1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 0, 0);   check("defuse_wins", 32'(state), 32'd2);
    step(1'b0, 1'b0, 1'b0, 1'b1, 40, 12); check("p40_12_pre", rgb_now(), 32'(K_BG));
    step(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 40, 12); check("p40_12_ok", rgb_now(), 32'(K_OK));

    // reset mid-frame while armed
    apply_reset("rst2");
    step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 5; i++) frame(4, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 30, 30);
    apply_reset("rst_mid");

    // randomized frames with sporadic arm/defuse
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 150; i++) frame($urandom_range(1, 6), 1'b1);
      apply_reset("rst_rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
